// File: rtl/hd_pkg.sv
// Shared defaults, FSM state encoding and the class-memory data type
// for the hypervector similarity / argmax block.
package hd_pkg;

    localparam int FTWIDTH    = 8;
    localparam int M_SIZE     = 16;
    localparam int ADDR_WIDTH = 13;
    localparam int ACC_WIDTH  = 32;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        ARGMAX,
        DONE
    } state_t;

    typedef logic [M_SIZE-1:0][FTWIDTH-1:0] class_vec_t;

endpackage

// File: rtl/hd_mac_lane.sv
// One class lane: signed element product, sign-extended and accumulated
// with wrap-around; clear has priority over enable.
module hd_mac_lane #(
    parameter int FTWIDTH   = 8,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic [FTWIDTH-1:0]   a,
    input  logic [FTWIDTH-1:0]   b,
    output logic [ACC_WIDTH-1:0] acc
);

    logic signed [2*FTWIDTH-1:0] prod;

    assign prod = $signed(a) * $signed(b);

    always_ff @(posedge clk) begin
        if (reset || clear)
            acc <= '0;
        else if (en)
            acc <= acc + {{(ACC_WIDTH-2*FTWIDTH){prod[2*FTWIDTH-1]}}, prod};
    end

endmodule

// File: rtl/hd_similarity_argmax.sv
// Streams a query hypervector against M_SIZE class banks, then scans the
// accumulators for the best signed score. HD_SCORE_OUT_EN adds scores_out.
module hd_similarity_argmax
    import hd_pkg::*;
#(
    parameter int DIM        = 8000,
    parameter int FTWIDTH    = hd_pkg::FTWIDTH,
    parameter int M_SIZE     = hd_pkg::M_SIZE,
    parameter int ADDR_WIDTH = hd_pkg::ADDR_WIDTH,
    parameter int ACC_WIDTH  = hd_pkg::ACC_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mem_ready,
    input  logic                        start,
    input  logic                        query_valid,
    input  logic [FTWIDTH-1:0]          query_data,
    output logic                        query_ready,
    output logic [ADDR_WIDTH-1:0]       read_address,
    input  logic [M_SIZE*FTWIDTH-1:0]   class_out,
    output logic                        busy,
    output logic                        result_valid,
    output logic [$clog2(M_SIZE)-1:0]   class_id,
    output logic [ACC_WIDTH-1:0]        best_score
`ifdef HD_SCORE_OUT_EN
    ,
    output logic [M_SIZE*ACC_WIDTH-1:0] scores_out
`endif
);

    localparam int IDXW = $clog2(M_SIZE);

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]             dim_cnt;
    logic [FTWIDTH-1:0]                q_d;
    logic                              v_d;
    logic [M_SIZE-1:0][ACC_WIDTH-1:0]  acc;
    logic [IDXW-1:0]                   scan_idx, best_idx, nb_idx;
    logic signed [ACC_WIDTH-1:0]       best_val, nb_val, cand;
    logic                              hs, last, clear, scan_last;

    assign hs        = query_valid && (state == ACCUM);
    assign last      = (dim_cnt == ADDR_WIDTH'(DIM-1));
    assign clear     = (state == IDLE) && start && mem_ready;
    assign scan_last = (scan_idx == IDXW'(M_SIZE-1));

    always_comb begin
        state_nx     = state;
        query_ready  = 1'b0;
        busy         = 1'b1;
        result_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (clear) state_nx = ACCUM;
            end
            ACCUM: begin
                query_ready = 1'b1;
                if (hs && last) state_nx = DRAIN;
            end
            DRAIN:  state_nx = ARGMAX;
            ARGMAX: if (scan_last) state_nx = DONE;
            DONE: begin
                result_valid = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // First scan slot seeds the best with acc[0]; only strictly greater wins.
    always_comb begin
        cand   = acc[scan_idx];
        nb_val = best_val;
        nb_idx = best_idx;
        if (scan_idx == '0 || cand > best_val) begin
            nb_val = cand;
            nb_idx = scan_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            dim_cnt      <= '0;
            read_address <= '0;
            q_d          <= '0;
            v_d          <= 1'b0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_val     <= '0;
            class_id     <= '0;
            best_score   <= '0;
        end else begin
            state <= state_nx;
            v_d   <= hs;
            if (hs) q_d <= query_data;
            if (clear) begin
                dim_cnt      <= '0;
                read_address <= '0;
            end else if (hs && !last) begin
                dim_cnt      <= dim_cnt + ADDR_WIDTH'(1);
                read_address <= dim_cnt + ADDR_WIDTH'(1);
            end
            if (state == DRAIN) scan_idx <= '0;
            if (state == ARGMAX) begin
                scan_idx <= scan_idx + IDXW'(1);
                best_val <= nb_val;
                best_idx <= nb_idx;
                if (scan_last) begin
                    class_id   <= nb_idx;
                    best_score <= nb_val;
                end
            end
        end
    end

    // Memory data lands one cycle after the address, aligned with q_d/v_d.
    for (genvar k = 0; k < M_SIZE; k++) begin : g_lane
        hd_mac_lane #(
            .FTWIDTH  (FTWIDTH),
            .ACC_WIDTH(ACC_WIDTH)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .clear(clear),
            .en   (v_d),
            .a    (q_d),
            .b    (class_out[k*FTWIDTH +: FTWIDTH]),
            .acc  (acc[k])
        );
    end

`ifdef HD_SCORE_OUT_EN
    assign scores_out = acc;
`endif

endmodule

// File: tb/tb_hd_similarity_argmax.sv
// Directed bench: a DIM=4 instance with a 1-cycle memory model and a
// default-DIM instance for the extreme-value accumulation case.
module tb_hd_similarity_argmax;
    import hd_pkg::*;

    localparam int SD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, mem_ready, start, query_valid;
    logic [7:0]  query_data;
    logic        query_ready, busy, result_valid;
    logic [12:0] read_address;
    logic [127:0] class_out;
    logic [3:0]  class_id;
    logic [31:0] best_score;

    logic        mem_ready_b, start_b, qv_b;
    logic [7:0]  query_data_b;
    logic        query_ready_b, busy_b, result_valid_b;
    logic [12:0] read_address_b;
    logic [127:0] class_out_b;
    logic [3:0]  class_id_b;
    logic [31:0] best_score_b;
`ifdef HD_SCORE_OUT_EN
    logic [511:0] scores, scores_b;
`endif

    hd_similarity_argmax #(.DIM(SD)) dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .start(start),
        .query_valid(query_valid), .query_data(query_data),
        .query_ready(query_ready), .read_address(read_address),
        .class_out(class_out), .busy(busy), .result_valid(result_valid),
        .class_id(class_id), .best_score(best_score)
`ifdef HD_SCORE_OUT_EN
        , .scores_out(scores)
`endif
    );

    hd_similarity_argmax dut_big (
        .clk(clk), .reset(reset), .mem_ready(mem_ready_b), .start(start_b),
        .query_valid(qv_b), .query_data(query_data_b),
        .query_ready(query_ready_b), .read_address(read_address_b),
        .class_out(class_out_b), .busy(busy_b), .result_valid(result_valid_b),
        .class_id(class_id_b), .best_score(best_score_b)
`ifdef HD_SCORE_OUT_EN
        , .scores_out(scores_b)
`endif
    );

    // mem[addr][k] is element addr of class k
    class_vec_t mem [SD];
    always @(posedge clk) class_out <= mem[read_address[1:0]];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_lin(input bit rev);
        for (int a = 0; a < SD; a++)
            for (int k = 0; k < 16; k++)
                mem[a][k] = rev ? 8'(15 - k) : 8'(k);
    endtask

    task automatic load_tie;
        for (int a = 0; a < SD; a++)
            for (int k = 0; k < 16; k++)
                mem[a][k] = (k == 3 || k == 9) ? 8'hFE : 8'h00;
    endtask

    task automatic run_query(input string tag, input logic [7:0] qv, input int gap,
                             input logic [3:0] exp_id, input logic [31:0] exp_score);
        int n, lat;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        for (int i = 0; i < SD; i++) begin
            query_valid = 1'b1;
            query_data  = qv;
            n = 0;
            while (!query_ready && n < 20) begin tick; n++; end
            chk({tag, "_rdy"}, query_ready, 1);
            chk({tag, "_addr"}, read_address, i);
            tick;
            query_valid = 1'b0;
            if (i < SD - 1)
                for (int b = 0; b < gap; b++) begin
                    tick;
                    chk({tag, "_hold"}, read_address, i + 1);
                end
        end
        chk({tag, "_rdy_off"}, query_ready, 0);
        lat = 1;
        while (!result_valid && lat < 100) begin tick; lat++; end
        chk({tag, "_latency"}, lat, 18);
        chk({tag, "_id"}, class_id, exp_id);
        chk({tag, "_score"}, best_score, exp_score);
        tick;
        chk({tag, "_pulse"}, result_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_id_hold"}, class_id, exp_id);
    endtask

    initial begin
        int seen, n;
        reset = 1'b1; mem_ready = 1'b0; start = 1'b0;
        query_valid = 1'b0; query_data = '0;
        mem_ready_b = 1'b1; start_b = 1'b0; qv_b = 1'b0;
        query_data_b = 8'h80; class_out_b = {16{8'h80}};
        load_lin(1'b0);
        repeat (3) tick;
        chk("rst_ready", query_ready, 0);
        chk("rst_addr", read_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_id", class_id, 0);
        chk("rst_score", best_score, 0);
        reset = 1'b0;
        tick;

        // gating: start without mem_ready is ignored
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("gate_busy", busy, 0);
        chk("gate_ready", query_ready, 0);
        mem_ready = 1'b1;

        load_lin(1'b0);
        run_query("single", 8'd1, 0, 4'd15, 32'd60);
        chk("single_addr_last", read_address, SD - 1);
`ifdef HD_SCORE_OUT_EN
        chk("single_scores", scores[15*32 +: 32], 60);
`endif

        load_tie;
        run_query("tie", 8'hFF, 0, 4'd3, 32'd8);

        load_lin(1'b0);
        run_query("bubble", 8'd1, 2, 4'd15, 32'd60);

        load_lin(1'b1);
        run_query("gate", 8'd1, 0, 4'd0, 32'd60);

        // reset in the middle of ACCUM
        load_tie;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            query_valid = 1'b1;
            query_data  = 8'hFF;
            tick;
        end
        query_valid = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("abort_ready", query_ready, 0);
        chk("abort_addr", read_address, 0);
        chk("abort_busy", busy, 0);
        chk("abort_valid", result_valid, 0);
        chk("abort_id", class_id, 0);
        chk("abort_score", best_score, 0);
        seen = 0;
        repeat (30) begin
            tick;
            if (result_valid) seen = 1;
        end
        chk("abort_no_result", seen, 0);
        run_query("post_rst", 8'hFF, 0, 4'd3, 32'd8);

        // full-length extreme values on the default-DIM instance
        chk("big_rst_busy", busy_b, 0);
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        qv_b = 1'b1;
        n = 0;
        while (!result_valid_b && n < 9000) begin tick; n++; end
        qv_b = 1'b0;
        chk("big_done", result_valid_b, 1);
        chk("big_id", class_id_b, 0);
        chk("big_score", best_score_b, 32'd131072000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
